// File: rtl/regfile_pkg.sv
// Shared constants and types for the register file and its write-port sequencing.
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first asserted request at or above ptr, wrapping to bit 0.
module rr_arbiter #(
    parameter int N = 3,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx
);

    logic [N-1:0] upper;
    logic [N-1:0] sel;

    // Requests at or above the pointer take priority; otherwise fall back to a plain lowest-index pick.
    for (genvar gi = 0; gi < N; gi++) begin : g_upper
        assign upper[gi] = req[gi] & (IW'(gi) >= ptr);
    end

    assign sel = (|upper) ? upper : req;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (sel[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IW'(i);
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Owns the regfile write port: post-reset clear sweep, then round-robin writeback arbitration.
module regfile_wr_arbiter
    import regfile_pkg::*;
#(
    parameter int          NREQ       = 3,
    parameter bit          INIT_EN    = 1'b1,
    parameter logic [31:0] INIT_VALUE = 32'h0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*REG_ADDR_W-1:0] req_addr,
    input  logic [NREQ*REG_DATA_W-1:0] req_data,
    output logic [NREQ-1:0]            req_ready,
    output logic                       rf_we,
    output logic [REG_ADDR_W-1:0]      rf_rw,
    output logic [REG_DATA_W-1:0]      rf_din,
    output logic                       init_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    rf_arb_state_t        st;
    logic [REG_ADDR_W-1:0] cnt;
    logic [IW-1:0]         rr_ptr;

    logic [NREQ-1:0]       gnt;
    logic [IW-1:0]         gnt_idx;
    logic                  any_gnt;
    logic [REG_ADDR_W-1:0] addr_arr [NREQ];
    logic [REG_DATA_W-1:0] data_arr [NREQ];
    logic [REG_ADDR_W-1:0] sel_addr;
    logic [REG_DATA_W-1:0] sel_data;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign addr_arr[gi] = req_addr[gi*REG_ADDR_W +: REG_ADDR_W];
        assign data_arr[gi] = req_data[gi*REG_DATA_W +: REG_DATA_W];
    end

    rr_arbiter #(.N(NREQ)) u_arb (
        .req     (req_valid),
        .ptr     (rr_ptr),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // Grants are masked during the sweep so no writeback can race the clear.
    assign req_ready = (st == RUN) ? gnt : '0;
    assign any_gnt   = |req_ready;
    assign sel_addr  = addr_arr[gnt_idx];
    assign sel_data  = data_arr[gnt_idx];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= INIT;
            cnt       <= '0;
            rr_ptr    <= '0;
            rf_we     <= 1'b0;
            rf_rw     <= '0;
            rf_din    <= '0;
            init_done <= 1'b0;
        end else if (st == INIT) begin
            if (INIT_EN) begin
                rf_we  <= 1'b1;
                rf_rw  <= cnt;
                rf_din <= INIT_VALUE;
                cnt    <= cnt + 1'b1;
                if (cnt == REG_ADDR_W'(NUM_REGS - 1)) begin
                    init_done <= 1'b1;
                    st        <= RUN;
                end
            end else begin
                rf_we     <= 1'b0;
                init_done <= 1'b1;
                st        <= RUN;
            end
        end else begin
            if (any_gnt) begin
                rf_rw  <= sel_addr;
                rf_din <= sel_data;
                // Writes to $zero complete the handshake but never reach the array.
                rf_we  <= (sel_addr != '0);
                rr_ptr <= (gnt_idx == IW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
            end else begin
                rf_we <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Randomized bench for regfile_wr_arbiter against a spec-level model of the sweep, grants and register contents.
module tb_regfile_wr_arbiter;

    localparam int          NREQ       = 3;
    localparam logic [31:0] INIT_VALUE = 32'h0;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ*5-1:0] req_addr;
    logic [NREQ*32-1:0] req_data;
    logic [NREQ-1:0]   req_ready;
    logic              rf_we;
    logic [4:0]        rf_rw;
    logic [31:0]       rf_din;
    logic              init_done;

    logic [NREQ-1:0]    z_valid;
    logic [NREQ*5-1:0]  z_addr;
    logic [NREQ*32-1:0] z_data;
    logic [NREQ-1:0]    d2_ready;
    logic               d2_we;
    logic [4:0]         d2_rw;
    logic [31:0]        d2_din;
    logic               d2_done;

    regfile_wr_arbiter #(.NREQ(NREQ), .INIT_EN(1'b1), .INIT_VALUE(INIT_VALUE)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rf_we     (rf_we),
        .rf_rw     (rf_rw),
        .rf_din    (rf_din),
        .init_done (init_done)
    );

    regfile_wr_arbiter #(.NREQ(NREQ), .INIT_EN(1'b0), .INIT_VALUE(32'h5555_5555)) dut_noinit (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (z_valid),
        .req_addr  (z_addr),
        .req_data  (z_data),
        .req_ready (d2_ready),
        .rf_we     (d2_we),
        .rf_rw     (d2_rw),
        .rf_din    (d2_din),
        .init_done (d2_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural register file driven by the DUT's write port.
    logic [31:0] shadow [32];
    initial for (int i = 0; i < 32; i++) shadow[i] = 32'hA5A5_A5A5;
    always @(posedge clk) if (rf_we) shadow[rf_rw] <= rf_din;

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Requester stimulus and reference model state.
    logic        v [NREQ];
    logic [4:0]  a [NREQ];
    logic [31:0] d [NREQ];
    int          running_m, init_k, ptr_m, last_g, txn_n;
    logic        exp_we, exp_done;
    logic [4:0]  exp_rw;
    logic [31:0] exp_din;
    logic [31:0] mem_m [32];

    task automatic pack();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]        = v[i];
            req_addr[i*5 +: 5]  = a[i];
            req_data[i*32 +: 32] = d[i];
        end
    endtask

    task automatic step();
        int g;
        logic [NREQ-1:0] eg;
        pack();
        #1;
        g = -1;
        if (running_m != 0) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (ptr_m + k) % NREQ;
                if (g < 0 && v[j]) g = j;
            end
        end
        eg = (g >= 0) ? NREQ'(1 << g) : '0;
        check_val("ready", 32'(req_ready), 32'(eg));
        check_val("onehot", 32'($onehot0(req_ready)), 32'd1);
        @(posedge clk);
        #1;
        if (running_m == 0) begin
            exp_we = 1'b1;
            exp_rw = 5'(init_k);
            exp_din = INIT_VALUE;
            mem_m[init_k] = INIT_VALUE;
            init_k++;
            if (init_k == 32) begin
                running_m = 1;
                exp_done  = 1'b1;
            end
        end else if (g >= 0) begin
            exp_rw  = a[g];
            exp_din = d[g];
            exp_we  = (a[g] != 5'd0);
            ptr_m   = (g + 1) % NREQ;
            if (exp_we) mem_m[a[g]] = d[g];
            txn_n++;
            $display("txn %0d: req%0d addr=%0d data=%h we=%0d", txn_n, g, a[g], d[g], exp_we);
        end else begin
            exp_we = 1'b0;
        end
        last_g = g;
        check_val("rf_we", 32'(rf_we), 32'(exp_we));
        check_val("rf_rw", 32'(rf_rw), 32'(exp_rw));
        check_val("rf_din", rf_din, exp_din);
        check_val("init_done", 32'(init_done), 32'(exp_done));
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_we", 32'(rf_we), 32'd0);
        check_val("rst_rw", 32'(rf_rw), 32'd0);
        check_val("rst_din", rf_din, 32'd0);
        check_val("rst_done", 32'(init_done), 32'd0);
        check_val("rst_ready", 32'(req_ready), 32'd0);
        running_m = 0; init_k = 0; ptr_m = 0;
        exp_we = 1'b0; exp_rw = '0; exp_din = '0; exp_done = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic idle();
        for (int i = 0; i < NREQ; i++) v[i] = 1'b0;
        step();
    endtask

    task automatic cmp_mem();
        for (int i = 0; i < 32; i++) check_val($sformatf("mem%0d", i), shadow[i], mem_m[i]);
    endtask

    initial begin
        int wait_n, max_wait;
        int waits [NREQ];
        rst_n = 1'b0;
        z_valid = '0; z_addr = '0; z_data = '0;
        txn_n = 0; last_g = -1;
        for (int i = 0; i < 32; i++) mem_m[i] = 32'hA5A5_A5A5;
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b0; a[i] = '0; d[i] = '0; waits[i] = 0;
        end
        pack();
        repeat (3) @(negedge clk);

        // Reset sweep with every requester already asking.
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1; a[i] = 5'($urandom_range(1, 31)); d[i] = $urandom;
        end
        do_reset();
        check_val("noinit_done_pre", 32'(d2_done), 32'd0);
        step();
        check_val("noinit_done", 32'(d2_done), 32'd1);
        check_val("noinit_we", 32'(d2_we), 32'd0);
        for (int k = 1; k < 32; k++) step();
        idle();
        idle();
        cmp_mem();

        // Single write from requester 1.
        v[1] = 1'b1; a[1] = 5'd5; d[1] = 32'hDEAD_BEEF;
        step();
        idle();
        check_val("single_commit", shadow[5], 32'hDEAD_BEEF);

        // Round-robin with all requesters continuously valid.
        for (int i = 0; i < NREQ; i++) begin
            v[i] = 1'b1; a[i] = 5'(8 + i); d[i] = 32'h1000 + 32'(i);
        end
        repeat (6) step();
        idle();

        // $zero write is accepted but dropped.
        v[0] = 1'b1; a[0] = 5'd0; d[0] = 32'h1234;
        step();
        idle();
        idle();
        check_val("zero_reg", shadow[0], 32'h0);

        // Backpressure: requester 2 holds a request while 0 and 1 compete.
        v[0] = 1'b1; a[0] = 5'd20; d[0] = 32'h0BAD_0000;
        v[1] = 1'b1; a[1] = 5'd21; d[1] = 32'h0BAD_0001;
        v[2] = 1'b1; a[2] = 5'd17; d[2] = 32'hCAFE_F00D;
        wait_n = 0;
        do begin
            step();
            wait_n++;
        end while (last_g != 2 && wait_n < 8);
        check_val("bp_latency", 32'(wait_n <= NREQ), 32'd1);
        idle();
        idle();
        check_val("bp_commit", shadow[17], 32'hCAFE_F00D);

        // Random traffic; non-granted requesters keep addr/data stable.
        max_wait = 0;
        for (int i = 0; i < NREQ; i++) begin v[i] = 1'b0; waits[i] = 0; end
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!v[i] && ($urandom % 3 != 0)) begin
                    v[i] = 1'b1; a[i] = 5'($urandom); d[i] = $urandom;
                end
            end
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (v[i]) begin
                    if (i == last_g) waits[i] = 0;
                    else waits[i]++;
                    if (waits[i] > max_wait) max_wait = waits[i];
                end
            end
            if (last_g >= 0) v[last_g] = 1'b0;
        end
        check_val("fairness", 32'(max_wait < NREQ), 32'd1);
        idle();
        idle();
        cmp_mem();

        // Reset in the middle of the sweep, then a full restart.
        do_reset();
        repeat (10) step();
        do_reset();
        repeat (32) step();
        idle();
        idle();
        cmp_mem();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
